// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencing controller for a UART receiver.
// Drives the receiver enable, pulls the receiver out of its error state with a
// fixed low window on rx_en, and captures completed bytes into a
// first-word-fall-through FIFO for the host.
//
// Optional feature macro: UART_RX_CTRL_STATS_EN
//   defined   -> saturating err_cnt / ovf_cnt with clr_stats
//   undefined -> err_cnt / ovf_cnt tied to 0, clr_stats ignored
//
// FSM states:
//   state       | meaning
//   ST_OFF      | receiver disabled, waiting for ctrl_en
//   ST_ARMED    | receiver enabled, watching for error edges
//   ST_RECOVER  | rx_en held low for RECOVER_CYCLES to clear the receiver error
module uart_rx_ctrl #(
    parameter int DEPTH          = 16,
    parameter int RECOVER_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ctrl_en,
    input  logic                     clr_stats,
    input  logic                     rx_bussy,
    input  logic                     rx_error,
    input  logic                     rx_valid,
    input  logic [7:0]               RX_DATA,
    output logic                     rx_en,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               err_cnt,
    output logic [7:0]               ovf_cnt,
    output logic [1:0]               ctrl_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    localparam logic [TW-1:0] TIMER_LOAD = TW'(RECOVER_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_rx_en;
    logic [TW-1:0]   r_timer;

    logic            r_rx_error_d;
    logic            r_err_rise;
    logic            r_rx_valid_d;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic [7:0]      r_rd_data;

    logic            w_empty;
    logic            w_full;
    logic            w_push_req;
    logic            w_do_pop;
    logic            w_do_push;
    logic            w_drop;
    logic [AW-1:0]   w_rd_ptr_nxt;
    logic            w_head_is_new;

    // Receiver flags are registered once: the error edge is taken against the
    // registered copy and itself registered, so the FSM reacts one edge after
    // the rising level is first sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_error_d <= 1'b0;
            r_err_rise   <= 1'b0;
            r_rx_valid_d <= 1'b0;
        end else begin
            r_rx_error_d <= rx_error;
            r_err_rise   <= rx_error & ~r_rx_error_d;
            r_rx_valid_d <= rx_valid;
        end
    end

    // Control FSM with registered rx_en and recovery down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_OFF;
            r_rx_en <= 1'b0;
            r_timer <= '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (ctrl_en) begin
                        r_state <= ST_ARMED;
                        r_rx_en <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    // Host disable takes priority over a coincident error edge.
                    if (!ctrl_en) begin
                        r_state <= ST_OFF;
                        r_rx_en <= 1'b0;
                    end else if (r_err_rise) begin
                        r_state <= ST_RECOVER;
                        r_rx_en <= 1'b0;
                        r_timer <= TIMER_LOAD;
                    end
                end
                ST_RECOVER: begin
                    // Terminal count reached after RECOVER_CYCLES low cycles.
                    if (r_timer == '0) begin
                        if (ctrl_en) begin
                            r_state <= ST_ARMED;
                            r_rx_en <= 1'b1;
                        end else begin
                            r_state <= ST_OFF;
                            r_rx_en <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer - TIMER_ONE;
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                    r_rx_en <= 1'b0;
                end
            endcase
        end
    end

    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == LEVEL_FULL);

    // A byte is taken whenever the stop-bit flag was seen and the receiver does
    // not report a bad stop bit, independent of the control state, so a frame
    // in flight when the host disables reception still lands in the FIFO.
    assign w_push_req = r_rx_valid_d & ~rx_error;
    assign w_do_pop   = rd_en & ~w_empty;
    assign w_do_push  = w_push_req & (~w_full | w_do_pop);
    assign w_drop     = w_push_req & w_full & ~w_do_pop;

    assign w_rd_ptr_nxt  = w_do_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
    // The byte being written becomes the head when the FIFO is (or becomes) empty.
    assign w_head_is_new = w_do_push & (w_rd_ptr_nxt == r_wr_ptr);

    // FIFO storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= RX_DATA;
        end
    end

    // FIFO pointers, occupancy counter and registered head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_rd_data <= 8'h00;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            r_rd_ptr <= w_rd_ptr_nxt;

            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LEVEL_ONE;
                2'b01:   r_level <= r_level - LEVEL_ONE;
                default: r_level <= r_level;
            endcase

            if (w_head_is_new) begin
                r_rd_data <= RX_DATA;
            end else if (w_do_pop) begin
                r_rd_data <= r_mem[w_rd_ptr_nxt];
            end
        end
    end

`ifdef UART_RX_CTRL_STATS_EN
    logic [7:0] r_err_cnt;
    logic [7:0] r_ovf_cnt;
    logic       w_err_inc;

    // Errors only count while armed; edges during OFF or RECOVER are ignored.
    assign w_err_inc = (r_state == ST_ARMED) & r_err_rise;

    // Saturating statistics; a clear overrides any same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 8'h00;
            r_ovf_cnt <= 8'h00;
        end else if (clr_stats) begin
            r_err_cnt <= 8'h00;
            r_ovf_cnt <= 8'h00;
        end else begin
            if (w_err_inc && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_drop && (r_ovf_cnt != 8'hFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
        end
    end

    assign err_cnt = r_err_cnt;
    assign ovf_cnt = r_ovf_cnt;
`else
    logic w_stats_unused;

    assign w_stats_unused = clr_stats ^ w_drop;
    assign err_cnt        = 8'h00;
    assign ovf_cnt        = 8'h00;
`endif

    // rx_bussy is informational; the controller never truncates a frame.
    logic w_unused;
    assign w_unused = rx_bussy;

    assign rx_en      = r_rx_en;
    assign ctrl_state = r_state;
    assign rd_data    = r_rd_data;
    assign empty      = w_empty;
    assign full       = w_full;
    assign level      = r_level;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based reference model.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 16;
    localparam int RC    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ctrl_en;
    logic          clr_stats;
    logic          rx_bussy;
    logic          rx_error;
    logic          rx_valid;
    logic [7:0]    RX_DATA;
    logic          rx_en;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [LW-1:0] level;
    logic [7:0]    err_cnt;
    logic [7:0]    ovf_cnt;
    logic [1:0]    ctrl_state;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DEPTH(DEPTH), .RECOVER_CYCLES(RC)) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_en    (ctrl_en),
        .clr_stats  (clr_stats),
        .rx_bussy   (rx_bussy),
        .rx_error   (rx_error),
        .rx_valid   (rx_valid),
        .RX_DATA    (RX_DATA),
        .rx_en      (rx_en),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .err_cnt    (err_cnt),
        .ovf_cnt    (ovf_cnt),
        .ctrl_state (ctrl_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 OFF, 1 ARMED, 2 RECOVER.
    int             m_mode;
    int             m_low;
    bit             m_e1;      // rx_error sampled one edge ago
    bit             m_e2;      // rx_error sampled two edges ago
    bit             m_v1;      // rx_valid sampled one edge ago
    byte unsigned   m_q[$];
    int             m_err;
    int             m_ovf;

    task model_edge();
        bit rise;
        bit push_req;
        bit was_full;
        bit pop;
        bit drop;
        if (rst) begin
            m_mode = 0; m_low = 0;
            m_e1 = 1'b0; m_e2 = 1'b0; m_v1 = 1'b0;
            m_q.delete();
            m_err = 0; m_ovf = 0;
            return;
        end
        rise     = m_e1 && !m_e2;
        push_req = m_v1 && !rx_error;
        was_full = (m_q.size() == DEPTH);
        pop      = rd_en && (m_q.size() > 0);
        drop     = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (push_req) begin
            if (was_full && !pop) drop = 1'b1;
            else m_q.push_back(RX_DATA);
        end
        if (STATS) begin
            if (clr_stats) begin
                m_err = 0; m_ovf = 0;
            end else begin
                if (m_mode == 1 && rise && m_err < 255) m_err++;
                if (drop && m_ovf < 255) m_ovf++;
            end
        end
        case (m_mode)
            0: if (ctrl_en) m_mode = 1;
            1: begin
                if (!ctrl_en) m_mode = 0;
                else if (rise) begin m_mode = 2; m_low = 0; end
            end
            default: begin
                m_low++;
                if (m_low == RC) m_mode = ctrl_en ? 1 : 0;
            end
        endcase
        m_e2 = m_e1;
        m_e1 = rx_error;
        m_v1 = rx_valid;
    endtask

    task compare_all();
        chk("ctrl_state", ctrl_state, m_mode);
        chk("rx_en", rx_en, (m_mode == 1) ? 1 : 0);
        chk("level", level, m_q.size());
        chk("empty", empty, (m_q.size() == 0) ? 1 : 0);
        chk("full", full, (m_q.size() == DEPTH) ? 1 : 0);
        chk("err_cnt", err_cnt, m_err);
        chk("ovf_cnt", ovf_cnt, m_ovf);
        if (m_q.size() > 0) chk("rd_data", rd_data, m_q[0]);
    endtask

    task step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task send_byte(input logic [7:0] d);
        rx_valid = 1'b1;
        RX_DATA  = d;
        step();
        rx_valid = 1'b0;
        step();
    endtask

    initial begin
        int low;
        rst = 1'b1; ctrl_en = 1'b0; clr_stats = 1'b0; rx_bussy = 1'b0;
        rx_error = 1'b0; rx_valid = 1'b0; RX_DATA = 8'h00; rd_en = 1'b0;
        m_mode = 0; m_low = 0; m_e1 = 0; m_e2 = 0; m_v1 = 0; m_err = 0; m_ovf = 0;
        step();
        step();
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;

        // Basic capture
        ctrl_en = 1'b1;
        step();
        chk("cap_rx_en", rx_en, 1);
        send_byte(8'hA5);
        chk("cap_data", rd_data, 8'hA5);
        chk("cap_level", level, 1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("cap_popped", empty, 1);

        // Error recovery with a second edge inside the window
        rx_error = 1'b1;
        step();
        rx_error = 1'b0;
        step();
        low = 0;
        for (int i = 0; i < 40 && rx_en == 1'b0; i++) begin
            low++;
            if (i == 5) rx_error = 1'b1;
            if (i == 6) rx_error = 1'b0;
            step();
        end
        chk("recover_len", low, RC);
        chk("recover_err", err_cnt, STATS ? 1 : 0);

        // Overflow: 17 bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_byte(8'(i));
        chk("ovf_full", full, 1);
        chk("ovf_level", level, DEPTH);
        chk("ovf_cnt1", ovf_cnt, STATS ? 1 : 0);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_read", rd_data, i);
            rd_en = 1'b1;
            step();
            rd_en = 1'b0;
        end
        for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i));
        rx_valid = 1'b1; RX_DATA = 8'h77;
        step();
        rx_valid = 1'b0; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("popush_level", level, DEPTH);
        chk("popush_ovf", ovf_cnt, STATS ? 1 : 0);
        rd_en = 1'b1;
        repeat (DEPTH) step();
        rd_en = 1'b0;

        // Bad stop bit
        rx_valid = 1'b1; RX_DATA = 8'h5A;
        step();
        rx_valid = 1'b0; rx_error = 1'b1;
        step();
        rx_error = 1'b0;
        step();
        chk("bad_state", ctrl_state, 2);
        chk("bad_level", level, 0);
        chk("bad_err", err_cnt, STATS ? 2 : 0);
        repeat (RC + 4) step();

        // Mid-frame disable
        rx_bussy = 1'b1; ctrl_en = 1'b0; rx_valid = 1'b1; RX_DATA = 8'h3C;
        step();
        chk("mid_rx_en", rx_en, 0);
        rx_valid = 1'b0; rx_bussy = 1'b0;
        step();
        chk("mid_data", rd_data, 8'h3C);
        chk("mid_state", ctrl_state, 0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;

        // Saturation and clear
        ctrl_en = 1'b1;
        step();
        for (int i = 0; i < 300; i++) begin
            rx_error = 1'b1;
            step();
            rx_error = 1'b0;
            repeat (RC + 3) step();
        end
        chk("err_sat", err_cnt, STATS ? 255 : 0);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("err_clr", err_cnt, 0);

        // Reset with stored bytes
        for (int i = 0; i < 5; i++) send_byte(8'(8'h90 + i));
        chk("pre_rst_level", level, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_rx_en", rx_en, 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 29) == 0) ctrl_en = ~ctrl_en;
            if ($urandom_range(0, 24) == 0) rx_error = ~rx_error;
            clr_stats = ($urandom_range(0, 199) == 0);
            rx_bussy  = 1'($urandom_range(0, 1));
            if (rx_valid) rx_valid = 1'b0;
            else if ($urandom_range(0, 2) == 0) begin
                rx_valid = 1'b1;
                RX_DATA  = 8'($urandom);
            end
            rd_en = (i < 2000) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Sequencing controller for the UART receiver. It drives the receiver's enable, watches its busy/valid/error flags, and captures each completed byte into a first-word-fall-through FIFO for the host. On a receive error it pulls the receiver out of its error state by dropping the enable for a fixed recovery window. It sits between the receiver and the host-side byte consumer and optionally keeps saturating error and overflow statistics.

## Interface
- DEPTH, 16, FIFO depth in bytes; power of two, at least 2.
- RECOVER_CYCLES, 16, clk cycles rx_en is held low after an error; at least 1.

- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- ctrl_en  in  1  host enable for reception.
- clr_stats  in  1  synchronous clear of err_cnt and ovf_cnt.
- rx_bussy  in  1  receiver busy flag.
- rx_error  in  1  receiver error flag, level.
- rx_valid  in  1  receiver stop-bit state flag, one cycle.
- RX_DATA  in  8  receiver output byte; updated on the edge that ends rx_valid.
- rx_en  out  1  receiver enable, registered.
- rd_en  in  1  pop request from host.
- rd_data  out  8  FIFO head; valid while empty=0.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- err_cnt  out  8  receive errors, saturating at 255.
- ovf_cnt  out  8  bytes dropped on full FIFO, saturating at 255.
- ctrl_state  out  2  current state: 0 OFF, 1 ARMED, 2 RECOVER.

## Operation
- States:
  - OFF (rx_en=0): goes to ARMED when ctrl_en=1.
  - ARMED (rx_en=1): goes to OFF when ctrl_en=0. Goes to RECOVER on a rising edge of rx_error.
  - RECOVER (rx_en=0): counts RECOVER_CYCLES cycles. Then goes to ARMED if ctrl_en=1, else OFF.
- rx_en is registered and equals 1 exactly when the state is ARMED.
- Error detection:
  - Rising edge is detected against a registered copy of rx_error.
  - err_cnt increments once per rising edge, in ARMED only.
  - Errors seen in OFF or RECOVER are not counted.
- Byte capture:
  - A registered rx_valid_d flags a pending byte.
  - In the cycle where rx_valid_d=1 and rx_error=0, RX_DATA is pushed, in any state. This keeps an in-flight byte when ctrl_en drops mid-frame.
  - If rx_valid_d=1 and rx_error=1 (bad stop bit), nothing is pushed.
- Push when full:
  - Without a pop in the same cycle: the byte is dropped and ovf_cnt increments.
  - With a pop in the same cycle: the push is accepted and level is unchanged.
- Pop: rd_en with empty=1 is ignored. rd_en with empty=0 advances the head; rd_data shows the next entry one cycle later.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level is maintained as a counter.
- Counters saturate at 255; they never wrap.
- clr_stats zeroes both counters. If it coincides with an increment, clear wins.
- rx_bussy is informational only. Leaving ARMED never truncates a frame; the receiver finishes the byte in flight.

## Timing
- Reset values: rx_en=0, ctrl_state=0 (OFF), empty=1, full=0, level=0, err_cnt=0, ovf_cnt=0, rd_data=0. Pointers, rx_valid_d and the registered rx_error are cleared. FIFO memory is not cleared.
- Enable: ctrl_en sampled high at edge N gives rx_en=1 after edge N. Same for the low transition.
- Error: rx_error rises, seen at edge N. ctrl_state=2 and rx_en=0 after edge N+1. After exactly RECOVER_CYCLES cycles of rx_en low, the exit transition happens.
- Capture: rx_valid is high for the cycle before edge N. After edge N+1, the byte is in the FIFO: level+1 and empty=0.
- Capture-to-visible latency is 2 clk from rx_valid.
- rst asserted mid-frame or mid-recovery returns everything to reset values on the next edge. Stored bytes are discarded.

## Configuration
- UART_RX_CTRL_STATS_EN
  - Defined: err_cnt, ovf_cnt and clr_stats behave as above.
  - Undefined: counter logic is not built. err_cnt and ovf_cnt are tied to 0 and clr_stats is ignored. Recovery and drop behaviour are unchanged.

## Test plan
- **Basic capture:** ctrl_en=1, one rx_valid pulse with RX_DATA=0xA5 -> rx_en=1 after 1 cycle; 2 cycles after rx_valid, empty=0, level=1, rd_data=0xA5; rd_en pulse -> empty=1, level=0.
- **Error recovery:** rx_error rises while ARMED, RECOVER_CYCLES=16 -> rx_en low for exactly 16 cycles, then high; err_cnt=1; a second rising edge during RECOVER leaves err_cnt=1.
- **Overflow:** DEPTH=16; push 17 bytes 0x00..0x10 with no reads -> full=1, level=16, ovf_cnt=1; reading all 16 returns 0x00..0x0F. Push on full with rd_en in the same cycle -> accepted, ovf_cnt unchanged.
- **Bad stop bit:** rx_valid pulse followed by rx_error=1 in the next cycle -> no push, level unchanged, err_cnt+1, enters RECOVER.
- **Mid-frame disable:** ctrl_en dropped while rx_bussy=1, frame completes with 0x3C -> rx_en=0 next cycle, 0x3C still captured, ctrl_state=0.
- **Saturation and clear, plus reset:** 300 error edges -> err_cnt=255; clr_stats -> 0. rst with level=5 -> level=0, empty=1, rx_en=0 next cycle.
